mano_control_seq: RTL and testbench

Timing-and-control sequencer for the Mano basic computer. It owns the 3-bit sequence counter SC (T0..T6) and the instruction-decode state. Each cycle it drives the common-bus select code and the load/increment/clear strobes for AR, PC, DR, AC, IR, TR and memory. It sits beside the bus multiplexer and the register file, and is the only driver of the bus select.

---
 rtl/mano_pkg.sv | 54 +++++
 rtl/mano_rr_decode.sv | 26 ++
 rtl/mano_control_seq.sv | 194 +++++++++++++++++++
 tb/tb_mano_control_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared encodings for the Mano basic computer: bus selects, opcodes,
// ALU operations and the timing-step type used by the control sequencer.
package mano_pkg;

  localparam int SC_W = 3;

  typedef enum logic [2:0] {
    BUS_AR   = 3'd0,
    BUS_PC   = 3'd1,
    BUS_DR   = 3'd2,
    BUS_AC   = 3'd3,
    BUS_IR   = 3'd4,
    BUS_MEM  = 3'd5,
    BUS_TR   = 3'd6,
    BUS_NONE = 3'd7
  } bus_sel_e;

  typedef enum logic [1:0] {
    ALU_NONE = 2'd0,
    ALU_AND  = 2'd1,
    ALU_ADD  = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_e;

  typedef enum logic [SC_W-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } t_step_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RR  = 3'd7;

  // ALU function applied at T5 for the three AC-loading memory instructions.
  function automatic alu_op_e alu_for_op(input logic [2:0] op);
    unique case (op)
      OP_AND:  return ALU_AND;
      OP_ADD:  return ALU_ADD;
      OP_LDA:  return ALU_PASS;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mano_rr_decode.sv
// Register-reference decode: skip condition and halt request from the
// IR address field and the AC/E flags. Purely combinational.
module mano_rr_decode
  import mano_pkg::*;
(
  input  logic [11:0] rr_bits,
  input  logic        ac_msb,
  input  logic        ac_zero,
  input  logic        e_flag,
  output logic        skip,
  output logic        halt
);

  // The remaining register-reference bits act on the datapath, not here.
  logic rr_unused;
  assign rr_unused = ^rr_bits[11:5];

  // SPA, SNA, SZA, SZE in bit order 4..1; any enabled test that holds skips.
  assign skip = (rr_bits[4] & ~ac_msb)
              | (rr_bits[3] &  ac_msb)
              | (rr_bits[2] &  ac_zero)
              | (rr_bits[1] & ~e_flag);

  assign halt = rr_bits[0];

endmodule

// File: rtl/mano_control_seq.sv
// Timing-and-control sequencer for the Mano basic computer: owns SC (T0..T6),
// the latched opcode/indirect bit, and decodes bus select and strobes each step.
module mano_control_seq
  import mano_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        ac_msb,
  input  logic        ac_zero,
  input  logic        e_flag,
  input  logic        dr_zero,
  output logic [2:0]  bus_sel,
  output logic        ar_ld,
  output logic        ar_inc,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        dr_ld,
  output logic        dr_inc,
  output logic        ac_ld,
  output logic        ir_ld,
  output logic        tr_ld,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  alu_op,
  output logic        rr_exec,
  output logic [2:0]  sc,
  output logic        halted
);

  logic       run_q, run_d;
  t_step_e    sc_q, sc_d;
  logic [2:0] d_q, d_d;
  logic       i_q, i_d;

  logic     rr_skip, rr_halt;
  bus_sel_e bus_d;
  alu_op_e  alu_d;

  mano_rr_decode u_rr_decode (
    .rr_bits (ir[11:0]),
    .ac_msb  (ac_msb),
    .ac_zero (ac_zero),
    .e_flag  (e_flag),
    .skip    (rr_skip),
    .halt    (rr_halt)
  );

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    run_d = run_q;
    sc_d  = sc_q;
    d_d   = d_q;
    i_d   = i_q;
    if (!run_q) begin
      sc_d = T0;
      if (start) run_d = 1'b1;
    end else begin
      unique case (sc_q)
        T0: sc_d = T1;
        T1: sc_d = T2;
        T2: begin
          sc_d = T3;
          d_d  = ir[14:12];
          i_d  = ir[15];
        end
        T3: begin
          if (d_q == OP_RR) begin
            sc_d = T0;
            if (!i_q && rr_halt) run_d = 1'b0;
          end else begin
            sc_d = T4;
          end
        end
        T4: sc_d = (d_q == OP_STA || d_q == OP_BUN) ? T0 : T5;
        T5: sc_d = (d_q == OP_ISZ) ? T6 : T0;
        default: sc_d = T0;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      sc_q  <= T0;
      d_q   <= 3'd0;
      i_q   <= 1'b0;
    end else begin
      run_q <= run_d;
      sc_q  <= sc_d;
      d_q   <= d_d;
      i_q   <= i_d;
    end
  end

  // Outputs decode the current state directly, so an async reset clears them at once.
  always_comb begin
    bus_d   = BUS_NONE;
    alu_d   = ALU_NONE;
    ar_ld   = 1'b0;
    ar_inc  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    dr_ld   = 1'b0;
    dr_inc  = 1'b0;
    ac_ld   = 1'b0;
    ir_ld   = 1'b0;
    tr_ld   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    rr_exec = 1'b0;
    if (run_q) begin
      unique case (sc_q)
        T0: begin
          bus_d = BUS_PC;
          ar_ld = 1'b1;
        end
        T1: begin
          bus_d  = BUS_MEM;
          mem_rd = 1'b1;
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
        end
        T2: begin
          bus_d = BUS_IR;
          ar_ld = 1'b1;
        end
        T3: begin
          if (d_q != OP_RR && i_q) begin
            bus_d  = BUS_MEM;
            mem_rd = 1'b1;
            ar_ld  = 1'b1;
          end else if (d_q == OP_RR && !i_q) begin
            rr_exec = 1'b1;
            pc_inc  = rr_skip;
          end
        end
        T4: begin
          unique case (d_q)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_d  = BUS_MEM;
              mem_rd = 1'b1;
              dr_ld  = 1'b1;
            end
            OP_STA: begin
              bus_d  = BUS_AC;
              mem_wr = 1'b1;
            end
            OP_BUN: begin
              bus_d = BUS_AR;
              pc_ld = 1'b1;
            end
            OP_BSA: begin
              bus_d  = BUS_PC;
              mem_wr = 1'b1;
              ar_inc = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          unique case (d_q)
            OP_AND, OP_ADD, OP_LDA: begin
              ac_ld = 1'b1;
              alu_d = alu_for_op(d_q);
            end
            OP_BSA: begin
              bus_d = BUS_AR;
              pc_ld = 1'b1;
            end
            OP_ISZ: dr_inc = 1'b1;
            default: ;
          endcase
        end
        T6: begin
          if (d_q == OP_ISZ) begin
            bus_d  = BUS_DR;
            mem_wr = 1'b1;
            pc_inc = dr_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_sel = bus_d;
  assign alu_op  = alu_d;
  assign sc      = sc_q;
  assign halted  = ~run_q;

endmodule

// File: tb/tb_mano_control_seq.sv
// Directed self-checking bench for mano_control_seq: each task drives one
// scenario and compares a packed snapshot of all outputs against hand-built vectors.
module tb_mano_control_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] ir;
  logic        ac_msb, ac_zero, e_flag, dr_zero;
  logic [2:0]  bus_sel;
  logic        ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ir_ld, tr_ld;
  logic        mem_rd, mem_wr;
  logic [1:0]  alu_op;
  logic        rr_exec;
  logic [2:0]  sc;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  // Strobe bit masks, ordered as packed in the snapshot.
  localparam logic [10:0] AR_LD  = 11'h400;
  localparam logic [10:0] AR_INC = 11'h200;
  localparam logic [10:0] PC_LD  = 11'h100;
  localparam logic [10:0] PC_INC = 11'h080;
  localparam logic [10:0] DR_LD  = 11'h040;
  localparam logic [10:0] DR_INC = 11'h020;
  localparam logic [10:0] AC_LD  = 11'h010;
  localparam logic [10:0] IR_LD  = 11'h008;
  localparam logic [10:0] TR_LD  = 11'h004;
  localparam logic [10:0] MEM_RD = 11'h002;
  localparam logic [10:0] MEM_WR = 11'h001;

  mano_control_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ir      (ir),
    .ac_msb  (ac_msb),
    .ac_zero (ac_zero),
    .e_flag  (e_flag),
    .dr_zero (dr_zero),
    .bus_sel (bus_sel),
    .ar_ld   (ar_ld),
    .ar_inc  (ar_inc),
    .pc_ld   (pc_ld),
    .pc_inc  (pc_inc),
    .dr_ld   (dr_ld),
    .dr_inc  (dr_inc),
    .ac_ld   (ac_ld),
    .ir_ld   (ir_ld),
    .tr_ld   (tr_ld),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .alu_op  (alu_op),
    .rr_exec (rr_exec),
    .sc      (sc),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  // Snapshot layout: {bus_sel, strobes[10:0], alu_op, rr_exec, sc, halted}.
  function automatic logic [20:0] obs();
    return {bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ir_ld,
            tr_ld, mem_rd, mem_wr, alu_op, rr_exec, sc, halted};
  endfunction

  function automatic logic [20:0] ev(input logic [2:0] bus, input logic [10:0] st,
                                     input logic [1:0] alu, input logic rr,
                                     input logic [2:0] step, input logic h);
    return {bus, st, alu, rr, step, h};
  endfunction

  function automatic logic [20:0] fetch_v(input int t);
    case (t)
      0:       return ev(3'd1, AR_LD, 2'd0, 1'b0, 3'd0, 1'b0);
      1:       return ev(3'd5, MEM_RD | IR_LD | PC_INC, 2'd0, 1'b0, 3'd1, 1'b0);
      default: return ev(3'd4, AR_LD, 2'd0, 1'b0, 3'd2, 1'b0);
    endcase
  endfunction

  localparam logic [20:0] IDLE_V = {3'd7, 11'd0, 2'd0, 1'b0, 3'd0, 1'b1};

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ir = 16'h0000;
    ac_msb = 1'b0; ac_zero = 1'b0; e_flag = 1'b0; dr_zero = 1'b0;
    #2;
    checks++;
    if (obs() !== IDLE_V) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", obs(), IDLE_V);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== IDLE_V) begin
        failures++;
        $display("FAIL idle_hold cycle %0d: got %h expected %h", i, obs(), IDLE_V);
      end
    end
  endtask

  // Starts from halt; ends observing T0 of the next fetch.
  task automatic test_lda();
    logic [20:0] exp_q[$];
    for (int t = 0; t < 3; t++) exp_q.push_back(fetch_v(t));
    exp_q.push_back(ev(3'd7, 11'd0, 2'd0, 1'b0, 3'd3, 1'b0));
    exp_q.push_back(ev(3'd5, MEM_RD | DR_LD, 2'd0, 1'b0, 3'd4, 1'b0));
    exp_q.push_back(ev(3'd7, AC_LD, 2'd3, 1'b0, 3'd5, 1'b0));
    exp_q.push_back(fetch_v(0));
    ir = 16'h2010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL lda step %0d: got %h expected %h", i, obs(), exp_q[i]);
      end
    end
  endtask

  task automatic test_add_indirect();
    logic [20:0] exp_q[$];
    for (int t = 0; t < 3; t++) exp_q.push_back(fetch_v(t));
    exp_q.push_back(ev(3'd5, MEM_RD | AR_LD, 2'd0, 1'b0, 3'd3, 1'b0));
    exp_q.push_back(ev(3'd5, MEM_RD | DR_LD, 2'd0, 1'b0, 3'd4, 1'b0));
    exp_q.push_back(ev(3'd7, AC_LD, 2'd2, 1'b0, 3'd5, 1'b0));
    exp_q.push_back(fetch_v(0));
    ir = 16'h9020;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL add_ind step %0d: got %h expected %h", i, obs(), exp_q[i]);
      end
    end
  endtask

  task automatic test_bsa();
    logic [20:0] exp_q[$];
    for (int t = 0; t < 3; t++) exp_q.push_back(fetch_v(t));
    exp_q.push_back(ev(3'd7, 11'd0, 2'd0, 1'b0, 3'd3, 1'b0));
    exp_q.push_back(ev(3'd1, MEM_WR | AR_INC, 2'd0, 1'b0, 3'd4, 1'b0));
    exp_q.push_back(ev(3'd0, PC_LD, 2'd0, 1'b0, 3'd5, 1'b0));
    exp_q.push_back(fetch_v(0));
    ir = 16'h5030;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL bsa step %0d: got %h expected %h", i, obs(), exp_q[i]);
      end
    end
  endtask

  // Two ISZ passes: counter wraps to zero (skip), then not.
  task automatic test_isz();
    logic [20:0] exp_q[$];
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.delete();
      for (int t = 0; t < 3; t++) exp_q.push_back(fetch_v(t));
      exp_q.push_back(ev(3'd7, 11'd0, 2'd0, 1'b0, 3'd3, 1'b0));
      exp_q.push_back(ev(3'd5, MEM_RD | DR_LD, 2'd0, 1'b0, 3'd4, 1'b0));
      exp_q.push_back(ev(3'd7, DR_INC, 2'd0, 1'b0, 3'd5, 1'b0));
      exp_q.push_back(ev(3'd2, (pass == 0) ? (MEM_WR | PC_INC) : MEM_WR,
                         2'd0, 1'b0, 3'd6, 1'b0));
      exp_q.push_back(fetch_v(0));
      ir = 16'h6040;
      dr_zero = (pass == 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (obs() !== exp_q[i]) begin
          failures++;
          $display("FAIL isz%0d step %0d: got %h expected %h", pass, i, obs(), exp_q[i]);
        end
      end
    end
    dr_zero = 1'b0;
  endtask

  // STA then BUN back to back: both finish at T4.
  task automatic test_back_to_back();
    logic [20:0] exp_q[$];
    logic [15:0] ir_v[2] = '{16'h3050, 16'h4060};
    for (int k = 0; k < 2; k++) begin
      exp_q.delete();
      for (int t = 0; t < 3; t++) exp_q.push_back(fetch_v(t));
      exp_q.push_back(ev(3'd7, 11'd0, 2'd0, 1'b0, 3'd3, 1'b0));
      exp_q.push_back((k == 0) ? ev(3'd3, MEM_WR, 2'd0, 1'b0, 3'd4, 1'b0)
                               : ev(3'd0, PC_LD, 2'd0, 1'b0, 3'd4, 1'b0));
      exp_q.push_back(fetch_v(0));
      ir = ir_v[k];
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (obs() !== exp_q[i]) begin
          failures++;
          $display("FAIL sta_bun%0d step %0d: got %h expected %h", k, i, obs(), exp_q[i]);
        end
      end
    end
  endtask

  // Register-reference skips and an I/O NOP, all four cycles long.
  task automatic test_rr_skip();
    logic [20:0] exp_q[$];
    logic [15:0] ir_v[4]  = '{16'h7004, 16'h7004, 16'h7010, 16'hF000};
    logic        az_v[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [10:0] st_v[4]  = '{PC_INC, 11'd0, PC_INC, 11'd0};
    logic        rr_v[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      exp_q.delete();
      for (int t = 0; t < 3; t++) exp_q.push_back(fetch_v(t));
      exp_q.push_back(ev(3'd7, st_v[k], 2'd0, rr_v[k], 3'd3, 1'b0));
      exp_q.push_back(fetch_v(0));
      ir = ir_v[k];
      ac_zero = az_v[k];
      ac_msb = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (obs() !== exp_q[i]) begin
          failures++;
          $display("FAIL rr%0d step %0d: got %h expected %h", k, i, obs(), exp_q[i]);
        end
      end
    end
    ac_zero = 1'b0;
  endtask

  // HLT with a start pulse on the same edge: the start must be ignored.
  task automatic test_halt();
    logic [20:0] exp_q[$];
    for (int t = 0; t < 3; t++) exp_q.push_back(fetch_v(t));
    exp_q.push_back(ev(3'd7, 11'd0, 2'd0, 1'b1, 3'd3, 1'b0));
    ir = 16'h7001;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL hlt step %0d: got %h expected %h", i, obs(), exp_q[i]);
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs() !== IDLE_V) begin
        failures++;
        $display("FAIL hlt_idle cycle %0d: got %h expected %h", i, obs(), IDLE_V);
      end
    end
  endtask

  // Async reset during STA T4 drops mem_wr without a clock edge.
  task automatic test_reset_mid_sta();
    logic [20:0] exp_q[$];
    for (int t = 0; t < 3; t++) exp_q.push_back(fetch_v(t));
    exp_q.push_back(ev(3'd7, 11'd0, 2'd0, 1'b0, 3'd3, 1'b0));
    exp_q.push_back(ev(3'd3, MEM_WR, 2'd0, 1'b0, 3'd4, 1'b0));
    ir = 16'h3070;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL sta_rst step %0d: got %h expected %h", i, obs(), exp_q[i]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== IDLE_V) begin
      failures++;
      $display("FAIL async_reset: got %h expected %h", obs(), IDLE_V);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== IDLE_V) begin
      failures++;
      $display("FAIL post_reset_idle: got %h expected %h", obs(), IDLE_V);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (obs() !== fetch_v(0)) begin
      failures++;
      $display("FAIL restart_t0: got %h expected %h", obs(), fetch_v(0));
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_indirect();
    test_bsa();
    test_isz();
    test_back_to_back();
    test_rr_skip();
    test_halt();
    test_reset_mid_sta();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
